// File: rtl/seq_alu_mdu.sv
// seq_alu_mdu: handshaked execute-stage ALU with optional RV32M unit.
//
// The ten base ALU operations complete one cycle after accept. Multiply and
// divide run one bit per cycle on a shared 2*WIDTH-bit unsigned accumulator.
// Multiply is shift-add and divide is restoring. Signed operands are reduced
// to magnitudes at accept, and the sign is fixed up on the edge that enters
// DONE.
//
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   in_valid / in_ready  request handshake (in_ready high only in IDLE)
//   A, B, Op             operands and opcode, captured on the accept edge
//   out_valid/out_ready  result handshake (out_valid high only in DONE)
//   S, Zero, err         registered result, S==0 flag, illegal-op flag
module seq_alu_mdu #(
  parameter int WIDTH = 32,
  parameter int M_EXT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [4:0]       Op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] S,
  output logic             Zero,
  output logic             err
);

  localparam int SH_W = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};
  localparam bit M_ON = (M_EXT != 0);

  typedef enum logic [1:0] {ST_IDLE, ST_CALC, ST_DONE} state_t;

  state_t             state_q, state_d;
  logic [SH_W-1:0]    cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;   // mul: {partial, multiplier}; div: {rem, quo}
  logic [WIDTH-1:0]   b_q, b_d;       // multiplicand or divisor magnitude
  logic [2:0]         mop_q, mop_d;
  logic               neg_q, neg_d;   // negate the final result
  logic [WIDTH-1:0]   s_q, s_d;
  logic               zero_q, zero_d;
  logic               err_q, err_d;

  // ---------------- base ALU (evaluated on the accept edge) ----------------
  logic [SH_W-1:0]  shamt;
  logic [WIDTH-1:0] base_res;
  logic             base_legal;

  assign shamt = B[SH_W-1:0];

  always_comb begin
    base_res   = '0;
    base_legal = 1'b1;
    case (Op[3:0])
      4'b0000: base_res = A + B;
      4'b1000: base_res = A - B;
      4'b0001: base_res = A << shamt;
      4'b0010: base_res = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
      4'b0011: base_res = {{(WIDTH-1){1'b0}}, (A < B)};
      4'b0100: base_res = A ^ B;
      4'b0101: base_res = A >> shamt;
      4'b1101: base_res = WIDTH'($signed(A) >>> shamt);
      4'b0110: base_res = A | B;
      4'b0111: base_res = A & B;
      default: base_legal = 1'b0;
    endcase
  end

  // ---------------- M decode (evaluated on the accept edge) ----------------
  logic [2:0]       m_op;
  logic             m_is_div, a_sgn, b_sgn, a_neg, b_neg, res_neg;
  logic             div_by_zero, div_ovf;
  logic [WIDTH-1:0] a_mag, b_mag, special_res;

  always_comb begin
    m_op     = Op[2:0];
    m_is_div = m_op[2];
    // Signed A: MULH, MULHSU, DIV, REM. Signed B: MULH, DIV, REM.
    a_sgn = (m_op == 3'b001) || (m_op == 3'b010) || (m_op == 3'b100) || (m_op == 3'b110);
    b_sgn = (m_op == 3'b001) || (m_op == 3'b100) || (m_op == 3'b110);
    a_neg = a_sgn && A[WIDTH-1];
    b_neg = b_sgn && B[WIDTH-1];
    a_mag = a_neg ? (~A + 1'b1) : A;
    b_mag = b_neg ? (~B + 1'b1) : B;
    // Remainder follows the dividend's sign; everything else is sign(A)^sign(B).
    res_neg = (m_is_div && m_op[1]) ? a_neg : (a_neg ^ b_neg);
    div_by_zero = m_is_div && (B == '0);
    div_ovf     = m_is_div && !m_op[0] && (A == MOST_NEG) && (B == '1);
    special_res = '0;
    if (div_by_zero) begin
      special_res = m_op[1] ? A : '1;
    end else if (div_ovf) begin
      special_res = m_op[1] ? '0 : A;
    end
  end

  // ---------------- iteration step and final sign fix-up ----------------
  logic [WIDTH:0]     mul_sum, div_rsh, div_diff;
  logic [2*WIDTH-1:0] acc_step, prod_fix;
  logic [WIDTH-1:0]   quo, rem, fin_res;

  always_comb begin
    // Shift-add: add multiplicand to the upper half when the current
    // multiplier bit is set, then shift the whole accumulator right.
    mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, b_q} : '0);
    // Restoring divide: shift the next dividend bit into the remainder and
    // subtract the divisor only if it fits.
    div_rsh  = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    div_diff = div_rsh - {1'b0, b_q};
    if (!mop_q[2]) begin
      acc_step = {mul_sum, acc_q[WIDTH-1:1]};
    end else if (!div_diff[WIDTH]) begin
      acc_step = {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
    end else begin
      acc_step = {div_rsh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
    end

    prod_fix = neg_q ? (~acc_step + 1'b1) : acc_step;
    quo      = acc_step[WIDTH-1:0];
    rem      = acc_step[2*WIDTH-1:WIDTH];
    if (!mop_q[2]) begin
      fin_res = (mop_q[1:0] == 2'b00) ? prod_fix[WIDTH-1:0] : prod_fix[2*WIDTH-1:WIDTH];
    end else if (mop_q[1]) begin
      fin_res = neg_q ? (~rem + 1'b1) : rem;
    end else begin
      fin_res = neg_q ? (~quo + 1'b1) : quo;
    end
  end

  // ---------------- control ----------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    b_d     = b_q;
    mop_d   = mop_q;
    neg_d   = neg_q;
    s_d     = s_q;
    zero_d  = zero_q;
    err_d   = err_q;

    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          if (!Op[4] || !M_ON) begin
            // Base op, or an M op in a build without the M unit.
            state_d = ST_DONE;
            err_d   = Op[4] || !base_legal;
            s_d     = err_d ? '0 : base_res;
            zero_d  = (s_d == '0);
          end else if (div_by_zero || div_ovf) begin
            state_d = ST_DONE;
            err_d   = 1'b0;
            s_d     = special_res;
            zero_d  = (s_d == '0);
          end else begin
            state_d = ST_CALC;
            cnt_d   = '0;
            mop_d   = m_op;
            neg_d   = res_neg;
            acc_d   = m_is_div ? {{WIDTH{1'b0}}, a_mag} : {{WIDTH{1'b0}}, b_mag};
            b_d     = m_is_div ? b_mag : a_mag;
          end
        end
      end
      ST_CALC: begin
        acc_d = acc_step;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == SH_W'(WIDTH-1)) begin
          state_d = ST_DONE;
          cnt_d   = '0;
          err_d   = 1'b0;
          s_d     = fin_res;
          zero_d  = (fin_res == '0);
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      b_q     <= '0;
      mop_q   <= '0;
      neg_q   <= 1'b0;
      s_q     <= '0;
      zero_q  <= 1'b1;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      b_q     <= b_d;
      mop_q   <= mop_d;
      neg_q   <= neg_d;
      s_q     <= s_d;
      zero_q  <= zero_d;
      err_q   <= err_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign S         = s_q;
  assign Zero      = zero_q;
  assign err       = err_q;

endmodule

// File: tb/tb_seq_alu_mdu.sv
// Directed-vector bench for seq_alu_mdu (WIDTH=32, plus an M_EXT=0 copy).
// Latency is reported as the number of clock edges after the accept edge
// until out_valid is seen: 0 for single-cycle ops, 32 for iterative ops.
module tb_seq_alu_mdu;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, out_valid, out_ready, Zero, err;
  logic [31:0] A, B, S;
  logic [4:0]  Op;

  logic        x_in_valid, x_in_ready, x_out_valid, x_out_ready, x_zero, x_err;
  logic [31:0] x_a, x_b, x_s;
  logic [4:0]  x_op;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  seq_alu_mdu #(.WIDTH(32), .M_EXT(1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .Op(Op), .out_valid(out_valid), .out_ready(out_ready),
    .S(S), .Zero(Zero), .err(err)
  );

  seq_alu_mdu #(.WIDTH(32), .M_EXT(0)) dut_nom (
    .clk(clk), .rst(rst), .in_valid(x_in_valid), .in_ready(x_in_ready),
    .A(x_a), .B(x_b), .Op(x_op), .out_valid(x_out_valid), .out_ready(x_out_ready),
    .S(x_s), .Zero(x_zero), .err(x_err)
  );

  typedef struct {
    string       name;
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  // Drives one request, scrambles the inputs right after accept, waits
  // (bounded) for the result, then completes the output handshake.
  task automatic run_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output logic z, output logic e,
                        output int lat, output bit busy_ok);
    @(negedge clk);
    in_valid = 1'b1; Op = op; A = a; B = b;
    @(posedge clk); #1;
    in_valid = 1'b0; Op = 5'b01111; A = ~a; B = ~b;
    lat = 0;
    busy_ok = 1'b1;
    while (out_valid !== 1'b1 && lat < 200) begin
      if (in_ready !== 1'b0) busy_ok = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    if (in_ready !== 1'b0) busy_ok = 1'b0;
    res = S; z = Zero; e = err;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (S !== 32'h0) begin failures++; $display("FAIL reset_S got=%h exp=00000000", S); end
    checks++; if (Zero !== 1'b1) begin failures++; $display("FAIL reset_Zero got=%b exp=1", Zero); end
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", err); end
    $display("test_reset: in_ready=%b out_valid=%b S=%h Zero=%b err=%b", in_ready, out_valid, S, Zero, err);
  endtask

  task automatic test_base();
    vec_t v[$];
    logic [31:0] res; logic z, e; int lat; bit bok;
    v.push_back('{"ADD",  5'b00000, 32'd5,        32'd3,  32'd8,        0});
    v.push_back('{"SUB",  5'b01000, 32'd8,        32'd3,  32'd5,        0});
    v.push_back('{"SUB0", 5'b01000, 32'd3,        32'd3,  32'd0,        0});
    v.push_back('{"SRA",  5'b01101, 32'hFFFFFFF8, 32'd2,  32'hFFFFFFFE, 0});
    v.push_back('{"SRL",  5'b00101, 32'hFFFFFFF8, 32'd2,  32'h3FFFFFFE, 0});
    v.push_back('{"SLL",  5'b00001, 32'd4,        32'd34, 32'd16,       0});
    v.push_back('{"SLT",  5'b00010, 32'hFFFFFFFB, 32'd3,  32'd1,        0});
    v.push_back('{"SLTU", 5'b00011, 32'hFFFFFFFB, 32'd3,  32'd0,        0});
    v.push_back('{"XOR",  5'b00100, 32'h0000F0F0, 32'h0000FF00, 32'h00000FF0, 0});
    v.push_back('{"OR",   5'b00110, 32'h0000F0F0, 32'h0000FF00, 32'h0000FFF0, 0});
    v.push_back('{"AND",  5'b00111, 32'h0000F0F0, 32'h0000FF00, 32'h0000F000, 0});
    v.push_back('{"ADDW", 5'b00000, 32'hFFFFFFFF, 32'd2,  32'd1,        0});
    foreach (v[i]) begin
      run_op(v[i].op, v[i].a, v[i].b, res, z, e, lat, bok);
      checks++; if (res !== v[i].exp) begin failures++; $display("FAIL %s_S got=%h exp=%h", v[i].name, res, v[i].exp); end
      checks++; if (z !== (v[i].exp == 32'h0)) begin failures++; $display("FAIL %s_Zero got=%b exp=%b", v[i].name, z, (v[i].exp == 32'h0)); end
      checks++; if (e !== 1'b0) begin failures++; $display("FAIL %s_err got=%b exp=0", v[i].name, e); end
      checks++; if (lat !== v[i].lat) begin failures++; $display("FAIL %s_lat got=%0d exp=%0d", v[i].name, lat, v[i].lat); end
      $display("base %s A=%h B=%h S=%h Zero=%b err=%b lat=%0d", v[i].name, v[i].a, v[i].b, res, z, e, lat);
    end
  endtask

  task automatic test_mul_div();
    vec_t v[$];
    logic [31:0] res; logic z, e; int lat; bit bok;
    v.push_back('{"MULH",    5'b10001, 32'h80000000, 32'h80000000, 32'h40000000, 32});
    v.push_back('{"MUL",     5'b10000, 32'h80000000, 32'h80000000, 32'h00000000, 32});
    v.push_back('{"MULHU",   5'b10011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32});
    v.push_back('{"MULHSU",  5'b10010, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 32});
    v.push_back('{"MUL_op3", 5'b11000, 32'd5,        32'd7,        32'd35,       32});
    v.push_back('{"DIV",     5'b10100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 32});
    v.push_back('{"REM",     5'b10110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32});
    v.push_back('{"DIVU",    5'b10101, 32'd100,      32'd7,        32'd14,       32});
    v.push_back('{"REMU",    5'b10111, 32'd100,      32'd7,        32'd2,        32});
    v.push_back('{"DIVnb",   5'b10100, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 32});
    v.push_back('{"REMnb",   5'b10110, 32'd7,        32'hFFFFFFFE, 32'd1,        32});
    v.push_back('{"DIVU_z",  5'b10101, 32'd9,        32'd0,        32'hFFFFFFFF, 0});
    v.push_back('{"REM_z",   5'b10110, 32'd9,        32'd0,        32'd9,        0});
    v.push_back('{"DIV_ovf", 5'b10100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 0});
    v.push_back('{"REM_ovf", 5'b10110, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 0});
    foreach (v[i]) begin
      run_op(v[i].op, v[i].a, v[i].b, res, z, e, lat, bok);
      checks++; if (res !== v[i].exp) begin failures++; $display("FAIL %s_S got=%h exp=%h", v[i].name, res, v[i].exp); end
      checks++; if (z !== (v[i].exp == 32'h0)) begin failures++; $display("FAIL %s_Zero got=%b exp=%b", v[i].name, z, (v[i].exp == 32'h0)); end
      checks++; if (e !== 1'b0) begin failures++; $display("FAIL %s_err got=%b exp=0", v[i].name, e); end
      checks++; if (lat !== v[i].lat) begin failures++; $display("FAIL %s_lat got=%0d exp=%0d", v[i].name, lat, v[i].lat); end
      checks++; if (bok !== 1'b1) begin failures++; $display("FAIL %s_in_ready_busy got=%b exp=1", v[i].name, bok); end
      $display("mdu %s A=%h B=%h S=%h Zero=%b err=%b lat=%0d", v[i].name, v[i].a, v[i].b, res, z, e, lat);
    end
  endtask

  task automatic test_illegal();
    logic [31:0] res; logic z, e; int lat; bit bok;
    run_op(5'b01010, 32'd5, 32'd3, res, z, e, lat, bok);
    checks++; if (res !== 32'h0) begin failures++; $display("FAIL illegal_S got=%h exp=00000000", res); end
    checks++; if (e !== 1'b1) begin failures++; $display("FAIL illegal_err got=%b exp=1", e); end
    checks++; if (lat !== 0) begin failures++; $display("FAIL illegal_lat got=%0d exp=0", lat); end
    $display("illegal Op=01010 S=%h Zero=%b err=%b lat=%0d", res, z, e, lat);
    // A legal op afterwards must clear err again.
    run_op(5'b00000, 32'd0, 32'd0, res, z, e, lat, bok);
    checks++; if (e !== 1'b0) begin failures++; $display("FAIL illegal_clear_err got=%b exp=0", e); end
    $display("after_illegal ADD 0+0 S=%h err=%b", res, e);
  endtask

  task automatic test_backpressure();
    int n = 0;
    @(negedge clk);
    in_valid = 1'b1; Op = 5'b00000; A = 32'd5; B = 32'd3;
    @(posedge clk); #1;
    in_valid = 1'b0; A = 32'd0; B = 32'd0;
    for (int k = 0; k < 5; k++) begin
      checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL bp_out_valid cyc=%0d got=%b exp=1", k, out_valid); end
      checks++; if (S !== 32'd8) begin failures++; $display("FAIL bp_S cyc=%0d got=%h exp=00000008", k, S); end
      @(posedge clk); #1;
      n++;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL bp_in_ready_after got=%b exp=1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL bp_out_valid_after got=%b exp=0", out_valid); end
    $display("backpressure held %0d cycles S=%h in_ready=%b", n, S, in_ready);
  endtask

  task automatic test_back_to_back();
    int lat = 0;
    @(negedge clk);
    in_valid = 1'b1; Op = 5'b10101; A = 32'd100; B = 32'd7;
    @(posedge clk); #1;
    // Keep requesting a different op while busy; it must not be taken early.
    Op = 5'b00000; A = 32'd1; B = 32'd2;
    while (out_valid !== 1'b1 && lat < 200) begin @(posedge clk); #1; lat++; end
    checks++; if (S !== 32'd14) begin failures++; $display("FAIL b2b_first_S got=%h exp=0000000e", S); end
    checks++; if (lat !== 32) begin failures++; $display("FAIL b2b_first_lat got=%0d exp=32", lat); end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL b2b_gap_out_valid got=%b exp=0", out_valid); end
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL b2b_second_valid got=%b exp=1", out_valid); end
    checks++; if (S !== 32'd3) begin failures++; $display("FAIL b2b_second_S got=%h exp=00000003", S); end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    $display("back_to_back DIVU then ADD lat=%0d S=%h", lat, S);
  endtask

  task automatic test_reset_mid_op();
    logic [31:0] res; logic z, e; int lat; bit bok;
    @(negedge clk);
    in_valid = 1'b1; Op = 5'b10100; A = 32'd100; B = 32'd7;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rstmid_out_valid got=%b exp=0", out_valid); end
    checks++; if (S !== 32'h0) begin failures++; $display("FAIL rstmid_S got=%h exp=00000000", S); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL rstmid_in_ready got=%b exp=1", in_ready); end
    repeat (30) @(posedge clk);
    #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rstmid_no_result got=%b exp=0", out_valid); end
    run_op(5'b00000, 32'd1, 32'd1, res, z, e, lat, bok);
    checks++; if (res !== 32'd2) begin failures++; $display("FAIL rstmid_add_S got=%h exp=00000002", res); end
    checks++; if (lat !== 0) begin failures++; $display("FAIL rstmid_add_lat got=%0d exp=0", lat); end
    $display("reset_mid_op then ADD 1+1 S=%h lat=%0d", res, lat);
  endtask

  task automatic test_no_mext();
    @(negedge clk);
    checks++; if (x_in_ready !== 1'b1) begin failures++; $display("FAIL nom_in_ready got=%b exp=1", x_in_ready); end
    x_in_valid = 1'b1; x_op = 5'b10000; x_a = 32'd5; x_b = 32'd7;
    @(posedge clk); #1;
    x_in_valid = 1'b0;
    checks++; if (x_out_valid !== 1'b1) begin failures++; $display("FAIL nom_mul_lat got=%b exp=1", x_out_valid); end
    checks++; if (x_err !== 1'b1) begin failures++; $display("FAIL nom_mul_err got=%b exp=1", x_err); end
    checks++; if (x_s !== 32'h0) begin failures++; $display("FAIL nom_mul_S got=%h exp=00000000", x_s); end
    $display("no_mext MUL 5*7 S=%h err=%b out_valid=%b", x_s, x_err, x_out_valid);
    x_out_ready = 1'b1;
    @(posedge clk); #1;
    x_out_ready = 1'b0;
    @(negedge clk);
    x_in_valid = 1'b1; x_op = 5'b00000; x_a = 32'd5; x_b = 32'd7;
    @(posedge clk); #1;
    x_in_valid = 1'b0;
    checks++; if (x_s !== 32'd12) begin failures++; $display("FAIL nom_add_S got=%h exp=0000000c", x_s); end
    checks++; if (x_err !== 1'b0) begin failures++; $display("FAIL nom_add_err got=%b exp=0", x_err); end
    $display("no_mext ADD 5+7 S=%h err=%b", x_s, x_err);
    x_out_ready = 1'b1;
    @(posedge clk); #1;
    x_out_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    in_valid = 1'b0; out_ready = 1'b0; A = '0; B = '0; Op = '0;
    x_in_valid = 1'b0; x_out_ready = 1'b0; x_a = '0; x_b = '0; x_op = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    test_reset();
    test_base();
    test_mul_div();
    test_illegal();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_op();
    test_no_mext();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
